// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Opcode values are listed for reference; the scheduler forwards them without decoding.
package alu_sched_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OPC_W_DEF  = 4;
  localparam int TAG_W_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  localparam logic [3:0] OP_XFER  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADC   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_SBB   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NAND  = 4'd9;
  localparam logic [3:0] OP_NOR   = 4'd10;
  localparam logic [3:0] OP_XNOR  = 4'd11;
  localparam logic [3:0] OP_CMPEQ = 4'd12;
  localparam logic [3:0] OP_CMPLT = 4'd13;
  localparam logic [3:0] OP_CMPGT = 4'd14;
  localparam logic [3:0] OP_INC   = 4'd15;

endpackage

// File: rtl/alu_rr_scheduler_rr_arb2.sv
// Two-input round-robin arbiter: on contention the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = 1'b0;
    if (valid0 && valid1) begin
      grant_id = ~last_grant;
    end else if (valid1) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Optional per-requester grant counters are enabled with `define ALU_SCHED_PERF_EN.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OPC_W  = OPC_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_of,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cout,
  output logic              rsp_of
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  sched_state_e      state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [OPC_W-1:0]  alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              id_q, id_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_of_q, rsp_of_d;
  logic              grant_valid;
  logic              grant_id;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    id_d         = id_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_of_d     = rsp_of_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        req0_ready = grant_valid && !grant_id;
        req1_ready = grant_valid && grant_id;
        if (grant_valid) begin
          state_d      = EXEC;
          last_grant_d = grant_id;
          id_d         = grant_id;
          alu_opcode_d = grant_id ? req1_opcode : req0_opcode;
          alu_a_d      = grant_id ? req1_a      : req0_a;
          alu_b_d      = grant_id ? req1_b      : req0_b;
          tag_d        = grant_id ? req1_tag    : req0_tag;
        end
      end
      // The ALU has had a full cycle to settle on the registered operands.
      EXEC: begin
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_tag_d    = tag_q;
        rsp_result_d = alu_result;
        rsp_cout_d   = alu_cout;
        rsp_of_d     = alu_of;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      id_q         <= 1'b0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_of_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      id_q         <= id_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_of_q     <= rsp_of_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_of     = rsp_of_q;

`ifdef ALU_SCHED_PERF_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (req0_ready && grant_cnt0_q != 16'hFFFF) grant_cnt0_d = grant_cnt0_q + 16'd1;
    if (req1_ready && grant_cnt1_q != 16'hFFFF) grant_cnt1_d = grant_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: vector table, corner sequences, random traffic vs a transaction model.
// Grant counter checks are included when ALU_SCHED_PERF_EN is defined.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_opcode, req1_opcode;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_tag, req1_tag;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_cout, alu_of;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_of;
  logic [1:0] rsp_tag;
  logic [7:0] rsp_result;
`ifdef ALU_SCHED_PERF_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  alu_rr_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_of(rsp_of)
`ifdef ALU_SCHED_PERF_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Behavioural ALU: returns {cout, overflow, result}
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    s = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:        r = a;
      4'd1, 4'd15: s = {1'b0, a} + {1'b0, b};
      4'd2:        s = {1'b0, a} + {1'b0, b} + 9'd1;
      4'd3:        s = {1'b0, a} - {1'b0, b};
      4'd4:        s = {1'b0, a} - {1'b0, b} - 9'd1;
      4'd5:        r = ~a;
      4'd6:        r = a & b;
      4'd7:        r = a | b;
      4'd8:        r = a ^ b;
      4'd9:        r = ~(a & b);
      4'd10:       r = ~(a | b);
      4'd11:       r = ~(a ^ b);
      4'd12:       r = {7'd0, a == b};
      4'd13:       r = {7'd0, a < b};
      default:     r = {7'd0, a > b};
    endcase
    if (op == 4'd1 || op == 4'd2 || op == 4'd15) begin
      r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
    end else if (op == 4'd3 || op == 4'd4) begin
      r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]);
    end
    return {c, v, r};
  endfunction

  assign {alu_cout, alu_of, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

  // Transaction-level reference model
  bit         m_last = 1'b1;
  bit         m_pend = 1'b0;
  bit         m_rv = 1'b0;
  bit         m_id = 1'b0;
  logic [3:0] m_op = 4'd0;
  logic [7:0] m_a = 8'd0, m_b = 8'd0;
  logic [1:0] m_tag = 2'd0;
  bit         m_rid = 1'b0, m_cout = 1'b0, m_of = 1'b0;
  logic [1:0] m_rtag = 2'd0;
  logic [7:0] m_res = 8'd0;
  int         m_cnt0 = 0, m_cnt1 = 0;

  int checks = 0;
  int errors = 0;
  bit log_en = 1'b0;
  int glog[$];
  int rlog[$];

  typedef struct {
    bit         id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] tag;
    logic [7:0] res;
    bit         cout;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_ready(output bit e0, output bit e1);
    bit free;
    free = !m_pend && !m_rv;
    e0 = free && req0_valid && (!req1_valid || m_last);
    e1 = free && req1_valid && (!req0_valid || !m_last);
  endfunction

  task automatic checkOutput();
    bit e0, e1;
    exp_ready(e0, e1);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
    if (m_rv) begin
      chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_rid});
      chk("rsp_tag", {30'd0, rsp_tag}, {30'd0, m_rtag});
      chk("rsp_result", {24'd0, rsp_result}, {24'd0, m_res});
      chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, m_cout});
      chk("rsp_of", {31'd0, rsp_of}, {31'd0, m_of});
    end
    chk("alu_opcode", {28'd0, alu_opcode}, {28'd0, m_op});
    chk("alu_a", {24'd0, alu_a}, {24'd0, m_a});
    chk("alu_b", {24'd0, alu_b}, {24'd0, m_b});
`ifdef ALU_SCHED_PERF_EN
    chk("grant_cnt0", {16'd0, grant_cnt0}, m_cnt0);
    chk("grant_cnt1", {16'd0, grant_cnt1}, m_cnt1);
`endif
  endtask

  task automatic modelUpdate();
    bit e0, e1;
    if (rst) begin
      m_last = 1'b1; m_pend = 1'b0; m_rv = 1'b0;
      m_op = 4'd0; m_a = 8'd0; m_b = 8'd0;
      m_rid = 1'b0; m_rtag = 2'd0; m_res = 8'd0; m_cout = 1'b0; m_of = 1'b0;
      m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      exp_ready(e0, e1);
      if (m_pend) begin
        {m_cout, m_of, m_res} = alu_fn(m_op, m_a, m_b);
        m_rid = m_id; m_rtag = m_tag; m_rv = 1'b1; m_pend = 1'b0;
      end else if (m_rv) begin
        if (rsp_ready) m_rv = 1'b0;
      end else if (e0 || e1) begin
        m_pend = 1'b1; m_id = e1; m_last = e1;
        m_op  = e1 ? req1_opcode : req0_opcode;
        m_a   = e1 ? req1_a : req0_a;
        m_b   = e1 ? req1_b : req0_b;
        m_tag = e1 ? req1_tag : req0_tag;
        if (e0 && m_cnt0 < 65535) m_cnt0++;
        if (e1 && m_cnt1 < 65535) m_cnt1++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    if (log_en) begin
      if (req0_ready) glog.push_back(0);
      if (req1_ready) glog.push_back(1);
      if (rsp_valid && rsp_ready) rlog.push_back(int'(rsp_id));
    end
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = !v.id; req1_valid = v.id;
    if (v.id) begin
      req1_opcode = v.op; req1_a = v.a; req1_b = v.b; req1_tag = v.tag;
    end else begin
      req0_opcode = v.op; req0_a = v.a; req0_b = v.b; req0_tag = v.tag;
    end
  endtask

  task automatic randomizeReqs();
    req0_opcode = 4'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom); req0_tag = 2'($urandom);
    req1_opcode = 4'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom); req1_tag = 2'($urandom);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'd6,  8'hF0, 8'h3C, 2'd1, 8'h30, 1'b0};
    vecs[1] = '{1'b1, 4'd15, 8'hFF, 8'h01, 2'd2, 8'h00, 1'b1};
    vecs[2] = '{1'b0, 4'd8,  8'hAA, 8'h0F, 2'd3, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 4'd5,  8'h0F, 8'h77, 2'd0, 8'hF0, 1'b0};
    vecs[4] = '{1'b0, 4'd0,  8'h5A, 8'hC3, 2'd2, 8'h5A, 1'b0};
    vecs[5] = '{1'b1, 4'd3,  8'h10, 8'h20, 2'd1, 8'hF0, 1'b1};

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    randomizeReqs();
    @(posedge clk);
    modelUpdate();
    #1;
    step();
    step();
    chk("reset rsp_result", {24'd0, rsp_result}, 32'd0);
    chk("reset rsp_tag", {30'd0, rsp_tag}, 32'd0);
    chk("reset rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("reset rsp_cout", {31'd0, rsp_cout}, 32'd0);
    chk("reset rsp_of", {31'd0, rsp_of}, 32'd0);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      chk("vec rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("vec rsp_id", {31'd0, rsp_id}, {31'd0, vecs[i].id});
      chk("vec rsp_tag", {30'd0, rsp_tag}, {30'd0, vecs[i].tag});
      chk("vec rsp_result", {24'd0, rsp_result}, {24'd0, vecs[i].res});
      chk("vec rsp_cout", {31'd0, rsp_cout}, {31'd0, vecs[i].cout});
      step();
    end

    $display("[TB] continuous contention");
    glog.delete(); rlog.delete();
    log_en = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 40 && glog.size() < 6; i++) begin
      randomizeReqs();
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    log_en = 1'b0;
    chk("grant count", glog.size(), 32'd6);
    chk("rsp count", rlog.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < glog.size()) chk("grant order", glog[i], i % 2);
      if (i < rlog.size()) chk("rsp_id order", rlog[i], i % 2);
    end

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_opcode = 4'd7; req0_a = 8'h12; req0_b = 8'h34; req0_tag = 2'd3;
    step();
    req1_valid = 1'b1; req1_opcode = 4'd1; req1_a = 8'h01; req1_b = 8'h02; req1_tag = 2'd0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall rsp_result", {24'd0, rsp_result}, 32'h36);
      chk("stall req1_ready", {31'd0, req1_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("release req1_ready", {31'd0, req1_ready}, 32'd1);
    chk("release req0_ready", {31'd0, req0_ready}, 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    step();

    $display("[TB] reset during execute");
    req1_valid = 1'b1; req1_opcode = 4'd1; req1_a = 8'h03; req1_b = 8'h04; req1_tag = 2'd2;
    step();
    req1_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst alu_a", {24'd0, alu_a}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("rst req1_ready", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      randomizeReqs();
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      rsp_ready  = ($urandom_range(0, 99) < 70);
      rst        = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
